act_pwl_eval: RTL and testbench



---
 rtl/act_pkg.sv | 20 ++
 rtl/act_pwl_lane.sv | 75 +++++++
 rtl/act_pwl_eval.sv | 148 ++++++++++++++
 tb/tb_act_pwl_eval.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared constants and types for the piecewise-linear activation evaluator.
package act_pkg;

    localparam int LANE_W    = 8;
    localparam int FRAC_USED = 6;

    localparam logic FUNC_SIG  = 1'b0;
    localparam logic FUNC_TANH = 1'b1;

    localparam logic [LANE_W-1:0] SAT_SIG  = 8'hFF;
    localparam logic [LANE_W-1:0] SAT_TANH = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/act_pwl_lane.sv
// One lane: stage 1 registers slope*frac, stage 2 registers shift + offset add + saturate.
// Macro ACT_PWL_ROUND_EN selects round half-up instead of truncation for the shift.
module act_pwl_lane
    import act_pkg::*;
#(
    parameter int FRAC_SHIFT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_func,
    input  logic [LANE_W-1:0]    i_slope,
    input  logic [LANE_W-1:0]    i_offset,
    input  logic [FRAC_USED-1:0] i_frac,
    output logic [LANE_W-1:0]    o_res,
    output logic                 o_sat
);

    localparam int PROD_W = LANE_W + FRAC_USED;
    localparam int SUM_W  = PROD_W + 1;
    // Two spare bits keep offset + q from wrapping before the clamp compare.
    localparam int S_W    = PROD_W + 2;

    logic [PROD_W-1:0]       r_p;
    logic [LANE_W-1:0]       r_off;
    logic [LANE_W-1:0]       r_res;
    logic                    r_sat;

    logic [SUM_W-1:0]        w_p_adj;
    logic [PROD_W-1:0]       w_q;
    logic [S_W-1:0]          w_off_ext;
    logic signed [S_W-1:0]   w_s;
    logic signed [S_W-1:0]   w_lim_s;
    logic [LANE_W-1:0]       w_limit;
    logic                    w_clamp;

    always_comb begin
`ifdef ACT_PWL_ROUND_EN
        w_p_adj = {1'b0, r_p} + SUM_W'(1 << (FRAC_SHIFT - 1));
`else
        w_p_adj = {1'b0, r_p};
`endif
        w_q = PROD_W'(w_p_adj >> FRAC_SHIFT);
        if (i_func == FUNC_TANH) begin
            w_off_ext = {{(S_W - LANE_W){r_off[LANE_W-1]}}, r_off};
            w_limit   = SAT_TANH;
        end else begin
            w_off_ext = {{(S_W - LANE_W){1'b0}}, r_off};
            w_limit   = SAT_SIG;
        end
        w_s     = signed'(w_off_ext) + signed'({2'b00, w_q});
        w_lim_s = signed'(S_W'(w_limit));
        w_clamp = (w_s > w_lim_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= '0;
            r_off <= '0;
            r_res <= '0;
            r_sat <= 1'b0;
        end else begin
            if (i_valid) begin
                r_p   <= PROD_W'(i_slope) * PROD_W'(i_frac);
                r_off <= i_offset;
            end
            r_res <= w_clamp ? w_limit : w_s[LANE_W-1:0];
            r_sat <= w_clamp;
        end
    end

    assign o_res = r_res;
    assign o_sat = r_sat;

endmodule

// File: rtl/act_pwl_eval.sv
// Time-multiplexed PWL activation: one VEC_LANES vector in, PAR lanes per cycle, packed vector out.
// Optional macro ACT_PWL_ROUND_EN enables round half-up in each lane; latency is unchanged.
module act_pwl_eval
    import act_pkg::*;
#(
    parameter int VEC_LANES  = 64,
    parameter int PAR        = 8,
    parameter int FRAC_SHIFT = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        func_sel,
    input  logic [VEC_LANES*LANE_W-1:0] slope,
    input  logic [VEC_LANES*LANE_W-1:0] offset,
    input  logic [VEC_LANES*LANE_W-1:0] frac,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VEC_LANES*LANE_W-1:0] out_data,
    output logic                        sat_any,
    output logic [1:0]                  o_dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // in_ready is only high in IDLE and out_valid only in DONE, so the two never coincide.

    localparam int BEATS  = VEC_LANES / PAR;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = PAR * LANE_W;
    localparam int FBT_W  = PAR * FRAC_USED;

    state_t                          r_state;
    state_t                          w_next;
    logic [BW-1:0]                   r_beat;
    logic [BW-1:0]                   r_s1_beat;
    logic [BW-1:0]                   r_s2_beat;
    logic                            r_s1_valid;
    logic                            r_s2_valid;
    logic [VEC_LANES*LANE_W-1:0]     r_slope;
    logic [VEC_LANES*LANE_W-1:0]     r_offset;
    logic [VEC_LANES*FRAC_USED-1:0]  r_frac;
    logic                            r_func;
    logic [VEC_LANES*LANE_W-1:0]     r_out_data;
    logic                            r_sat_any;

    logic                            w_accept;
    logic                            w_issue;
    logic                            w_last_beat;
    logic                            w_pipe_empty;
    logic [BEAT_W-1:0]               w_slope_beat;
    logic [BEAT_W-1:0]               w_offset_beat;
    logic [FBT_W-1:0]                w_frac_beat;
    logic [BEAT_W-1:0]               w_res;
    logic [PAR-1:0]                  w_sat;
    logic                            w_unused_frac;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_next = ST_RUN;
            ST_RUN:   if (w_last_beat)  w_next = ST_DRAIN;
            ST_DRAIN: if (w_pipe_empty) w_next = ST_DONE;
            ST_DONE:  if (out_ready)    w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        w_issue   = (r_state == ST_RUN);
    end

    assign w_accept     = in_valid && in_ready;
    assign w_last_beat  = (r_beat == BW'(BEATS - 1));
    assign w_pipe_empty = !r_s1_valid && !r_s2_valid;

    // Vector capture; only the used fraction bits are kept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slope  <= slope;
            r_offset <= offset;
            r_func   <= func_sel;
            for (int i = 0; i < VEC_LANES; i++) begin
                r_frac[i*FRAC_USED +: FRAC_USED] <= frac[i*LANE_W +: FRAC_USED];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_s1_beat  <= '0;
            r_s2_beat  <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_sat_any  <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_beat  <= r_beat;
            r_s2_valid <= r_s1_valid;
            r_s2_beat  <= r_s1_beat;
            if (w_accept) begin
                r_beat    <= '0;
                r_sat_any <= 1'b0;
            end else if (w_issue) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_s2_valid) begin
                r_out_data[r_s2_beat*BEAT_W +: BEAT_W] <= w_res;
                r_sat_any <= r_sat_any | (|w_sat);
            end
        end
    end

    assign w_slope_beat  = r_slope[r_beat*BEAT_W +: BEAT_W];
    assign w_offset_beat = r_offset[r_beat*BEAT_W +: BEAT_W];
    assign w_frac_beat   = r_frac[r_beat*FBT_W +: FBT_W];

    for (genvar j = 0; j < PAR; j++) begin : g_lane
        act_pwl_lane #(
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (w_issue),
            .i_func   (r_func),
            .i_slope  (w_slope_beat[j*LANE_W +: LANE_W]),
            .i_offset (w_offset_beat[j*LANE_W +: LANE_W]),
            .i_frac   (w_frac_beat[j*FRAC_USED +: FRAC_USED]),
            .o_res    (w_res[j*LANE_W +: LANE_W]),
            .o_sat    (w_sat[j])
        );
    end

    assign w_unused_frac = ^frac;
    assign out_data      = r_out_data;
    assign sat_any       = r_sat_any;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_act_pwl_eval.sv
// Directed bench for act_pwl_eval; expectations follow ACT_PWL_ROUND_EN when it is defined.
module tb_act_pwl_eval;

    localparam int VL = 64;
    localparam int W  = VL * 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         func_sel = 1'b0;
    logic [W-1:0] slope = '0;
    logic [W-1:0] offset = '0;
    logic [W-1:0] frac = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         sat_any;
    logic [1:0]   dbg_state;

    int           checks = 0;
    int           failures = 0;
    int           lat;
    logic [W-1:0] exp_v;
    logic [W-1:0] vec_o;
    logic [W-1:0] vec_f;

    always #5 clk = ~clk;

    act_pwl_eval #(
        .VEC_LANES  (64),
        .PAR        (8),
        .FRAC_SHIFT (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .func_sel    (func_sel),
        .slope       (slope),
        .offset      (offset),
        .frac        (frac),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat_any     (sat_any),
        .o_dbg_state (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {VL{b}};
    endfunction

    // Present a vector, wait for acceptance, then scramble the buses.
    task automatic send(input logic fn, input logic [W-1:0] s, input logic [W-1:0] o,
                        input logic [W-1:0] f);
        int n;
        n = 0;
        func_sel = fn;
        slope    = s;
        offset   = o;
        frac     = f;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_ready", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        slope    = ~s;
        offset   = ~o;
        frac     = ~f;
        func_sel = ~fn;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_sat_any", W'(sat_any), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", W'(in_ready), W'(1));

        // Sigmoid basic: 62*16>>5 = 31, 128+31 = 159
        send(1'b0, rep(8'h3E), rep(8'h80), rep(8'h10));
        wait_out(lat);
        chk("sig_latency", W'(lat), W'(11));
        chk("sig_data", out_data, rep(8'h9F));
        chk("sig_sat", W'(sat_any), W'(0));
        take();
        chk("sig_idle_state", W'(dbg_state), W'(0));
        chk("sig_idle_ready", W'(in_ready), W'(1));
        chk("sig_idle_valid", W'(out_valid), W'(0));

        // Tanh: 5*31 = 155 -> q=4 (5 rounded), -8+q
        send(1'b1, rep(8'h05), rep(8'hF8), rep(8'h1F));
        wait_out(lat);
        chk("tanh_latency", W'(lat), W'(11));
`ifdef ACT_PWL_ROUND_EN
        chk("tanh_data", out_data, rep(8'hFD));
`else
        chk("tanh_data", out_data, rep(8'hFC));
`endif
        chk("tanh_sat", W'(sat_any), W'(0));
        take();

        // Sigmoid saturation on lane 3 only: q = 62*31>>5 = 60
        vec_o = '0;
        vec_o[3*8 +: 8] = 8'hF8;
        exp_v = rep(8'h3C);
        exp_v[3*8 +: 8] = 8'hFF;
        send(1'b0, rep(8'h3E), vec_o, rep(8'h1F));
        wait_out(lat);
        chk("sigsat_data", out_data, exp_v);
        chk("sigsat_flag", W'(sat_any), W'(1));
        take();

        // Tanh saturation: 96+60 = 156 > 127
        send(1'b1, rep(8'h3E), rep(8'h60), rep(8'h1F));
        wait_out(lat);
        chk("tanhsat_data", out_data, rep(8'h7F));
        chk("tanhsat_flag", W'(sat_any), W'(1));
        take();

        // Rounding boundary: 62*1 = 62 -> 1 truncated, 2 rounded
        send(1'b0, rep(8'h3E), rep(8'h00), rep(8'h01));
        wait_out(lat);
`ifdef ACT_PWL_ROUND_EN
        chk("round_data", out_data, rep(8'h02));
`else
        chk("round_data", out_data, rep(8'h01));
`endif
        chk("round_sat", W'(sat_any), W'(0));
        take();

        // Lane mapping: offset = lane index, frac upper bits set must be ignored
        for (int i = 0; i < VL; i++) begin
            vec_o[i*8 +: 8] = 8'(i);
`ifdef ACT_PWL_ROUND_EN
            exp_v[i*8 +: 8] = 8'(i + 2);
`else
            exp_v[i*8 +: 8] = 8'(i + 1);
`endif
        end
        send(1'b0, rep(8'h3E), vec_o, rep(8'hC1));
        wait_out(lat);
        chk("map_data", out_data, exp_v);
        chk("map_sat", W'(sat_any), W'(0));
        take();

        // Back-pressure with busy input buses
        send(1'b0, rep(8'h3E), rep(8'h80), rep(8'h10));
        wait_out(lat);
        chk("bp_latency", W'(lat), W'(11));
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            func_sel = 1'($urandom_range(0, 1));
            for (int i = 0; i < VL; i++) begin
                slope[i*8 +: 8]  = 8'($urandom_range(0, 255));
                offset[i*8 +: 8] = 8'($urandom_range(0, 255));
                frac[i*8 +: 8]   = 8'($urandom_range(0, 255));
            end
            step();
            chk("bp_data", out_data, rep(8'h9F));
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_out_valid", W'(out_valid), W'(1));
        end
        in_valid = 1'b0;
        take();
        chk("bp_release_state", W'(dbg_state), W'(0));
        chk("bp_release_valid", W'(out_valid), W'(0));

        // Reset during RUN at beat 3
        send(1'b0, rep(8'h3E), rep(8'hF8), rep(8'h1F));
        step();
        step();
        step();
        chk("mid_state_run", W'(dbg_state), W'(1));
        rst = 1'b1;
        step();
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_ready", W'(in_ready), W'(0));
        chk("mid_rst_state", W'(dbg_state), W'(0));
        step();
        rst = 1'b0;
        step();
        chk("mid_post_ready", W'(in_ready), W'(1));
        chk("mid_post_data", out_data, '0);
        chk("mid_post_sat", W'(sat_any), W'(0));
        send(1'b1, rep(8'h05), rep(8'hF8), rep(8'h1F));
        wait_out(lat);
        chk("mid_new_latency", W'(lat), W'(11));
`ifdef ACT_PWL_ROUND_EN
        chk("mid_new_data", out_data, rep(8'hFD));
`else
        chk("mid_new_data", out_data, rep(8'hFC));
`endif
        chk("mid_new_sat", W'(sat_any), W'(0));
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
